// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: exception codes, reset/handler vectors and the
// control bundle that travels alongside every instruction between stages.
package pipe_pkg;

    localparam int TNEW_W_DEF = 2;

    typedef logic [4:0] exc_t;

    localparam exc_t EXC_NONE = 5'd0;
    localparam exc_t EXC_ADEL = 5'd4;
    localparam exc_t EXC_ADES = 5'd5;
    localparam exc_t EXC_RI   = 5'd10;
    localparam exc_t EXC_OV   = 5'd12;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    // The tnew field is TNEW_W_DEF wide; stages configured wider are narrowed
    // into it, so keep TNEW_W at or below TNEW_W_DEF.
    typedef struct packed {
        logic [31:0]           pc;
        logic                  bd;
        exc_t                  exc;
        logic                  wr_en;
        logic [4:0]            wr_addr;
        logic [TNEW_W_DEF-1:0] tnew;
    } ctrl_t;

    // An exception raised earlier in the pipe belongs to an older instruction
    // point and must not be overwritten by one detected later.
    function automatic exc_t merge_exc(input exc_t older, input exc_t current);
        return (older != EXC_NONE) ? older : current;
    endfunction

    function automatic ctrl_t bubble_ctrl(input logic [31:0] pc, input logic bd);
        ctrl_t c;
        c     = '0;
        c.pc  = pc;
        c.bd  = bd;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the stage-boundary signals: hazard/CP0 controls, the incoming
// instruction fields and the registered outgoing fields.
interface pipe_stage_reg_if #(
    parameter int LANES  = 3,
    parameter int TNEW_W = 2
);

    logic                  en;
    logic                  flush;
    logic                  req;

    logic [31:0]           in_pc;
    logic                  in_bd;
    logic [4:0]            in_exc;
    logic [4:0]            stage_exc;
    logic                  in_wr_en;
    logic [4:0]            in_wr_addr;
    logic [TNEW_W-1:0]     in_tnew;
    logic [32*LANES-1:0]   in_payload;

    logic                  out_valid;
    logic [31:0]           out_pc;
    logic                  out_bd;
    logic [4:0]            out_exc;
    logic                  out_wr_en;
    logic [4:0]            out_wr_addr;
    logic [TNEW_W-1:0]     out_tnew;
    logic [32*LANES-1:0]   out_payload;

    // Upstream stage plus hazard unit side.
    modport master (
        output en, flush, req,
        output in_pc, in_bd, in_exc, stage_exc,
        output in_wr_en, in_wr_addr, in_tnew, in_payload,
        input  out_valid, out_pc, out_bd, out_exc,
        input  out_wr_en, out_wr_addr, out_tnew, out_payload
    );

    modport slave (
        input  en, flush, req,
        input  in_pc, in_bd, in_exc, stage_exc,
        input  in_wr_en, in_wr_addr, in_tnew, in_payload,
        output out_valid, out_pc, out_bd, out_exc,
        output out_wr_en, out_wr_addr, out_tnew, out_payload
    );

endinterface

// File: rtl/pipe_tnew_sat.sv
// Saturating T_new decrement; also used by the hazard unit to age the
// producer's T_new when comparing against consumer T_use.
module pipe_tnew_sat #(
    parameter int          TNEW_W   = 2,
    parameter int unsigned TNEW_DEC = 1
) (
    input  logic [TNEW_W-1:0] tnew_in,
    output logic [TNEW_W-1:0] tnew_out
);

    // One extra bit lets a decrement equal to 2**TNEW_W be represented.
    localparam int unsigned MAX_DEC   = 1 << TNEW_W;
    localparam int unsigned DEC_CLAMP = (TNEW_DEC > MAX_DEC) ? MAX_DEC : TNEW_DEC;
    localparam logic [TNEW_W:0] DEC   = (TNEW_W + 1)'(DEC_CLAMP);

    logic [TNEW_W:0] tnew_wide;
    logic [TNEW_W:0] tnew_diff;

    always_comb begin
        tnew_wide = {1'b0, tnew_in};
        tnew_diff = tnew_wide - DEC;
        tnew_out  = '0;
        if (tnew_wide > DEC) begin
            tnew_out = tnew_diff[TNEW_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register for the five-stage MIPS pipeline with hold,
// bubble insertion, exception-request redirect, exception merge and T_new aging.
module pipe_stage_reg #(
    parameter int          LANES          = 3,
    parameter int          TNEW_W         = pipe_pkg::TNEW_W_DEF,
    parameter int unsigned TNEW_DEC       = 1,
    parameter logic [31:0] RESET_PC       = pipe_pkg::RESET_PC,
    parameter logic [31:0] HANDLER_PC     = pipe_pkg::HANDLER_PC,
    parameter bit          BUBBLE_KEEP_PC = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_reg_if.slave   bus
);

    import pipe_pkg::*;

    logic                valid_d, valid_q;
    ctrl_t               ctrl_d, ctrl_q;
    logic [32*LANES-1:0] payload_d, payload_q;
    logic [TNEW_W-1:0]   tnew_aged;

    pipe_tnew_sat #(
        .TNEW_W   (TNEW_W),
        .TNEW_DEC (TNEW_DEC)
    ) u_tnew_sat (
        .tnew_in  (bus.in_tnew),
        .tnew_out (tnew_aged)
    );

    // req beats flush beats en; with none of them the register holds, which
    // also keeps T_new from aging during a stall.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        payload_d = payload_q;

        if (bus.req) begin
            valid_d   = 1'b0;
            ctrl_d    = bubble_ctrl(HANDLER_PC, 1'b0);
            payload_d = '0;
        end else if (bus.flush) begin
            valid_d   = 1'b0;
            payload_d = '0;
            if (BUBBLE_KEEP_PC) begin
                ctrl_d = bubble_ctrl(bus.in_pc, bus.in_bd);
            end else begin
                ctrl_d = bubble_ctrl(32'h0, 1'b0);
            end
        end else if (bus.en) begin
            valid_d        = 1'b1;
            ctrl_d.pc      = bus.in_pc;
            ctrl_d.bd      = bus.in_bd;
            ctrl_d.exc     = merge_exc(bus.in_exc, bus.stage_exc);
            ctrl_d.wr_en   = bus.in_wr_en && (bus.in_wr_addr != 5'd0);
            ctrl_d.wr_addr = bus.in_wr_addr;
            ctrl_d.tnew    = TNEW_W_DEF'(tnew_aged);
            payload_d      = bus.in_payload;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= bubble_ctrl(RESET_PC, 1'b0);
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            payload_q <= payload_d;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.out_pc      = ctrl_q.pc;
    assign bus.out_bd      = ctrl_q.bd;
    assign bus.out_exc     = ctrl_q.exc;
    assign bus.out_wr_en   = ctrl_q.wr_en;
    assign bus.out_wr_addr = ctrl_q.wr_addr;
    assign bus.out_tnew    = TNEW_W'(ctrl_q.tnew);
    assign bus.out_payload = payload_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with default parameters (LANES=3,
// TNEW_W=2, TNEW_DEC=1, BUBBLE_KEEP_PC=1); expected values are hand-computed.
module tb_pipe_stage_reg;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    pipe_stage_reg_if #(.LANES(3), .TNEW_W(2)) bus_if ();

    pipe_stage_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(
        input logic        en,
        input logic        flush,
        input logic        req,
        input logic [31:0] pc,
        input logic        bd,
        input logic [4:0]  exc,
        input logic [4:0]  stage_exc,
        input logic        wr_en,
        input logic [4:0]  wr_addr,
        input logic [1:0]  tnew,
        input logic [95:0] payload
    );
        bus_if.en         = en;
        bus_if.flush      = flush;
        bus_if.req        = req;
        bus_if.in_pc      = pc;
        bus_if.in_bd      = bd;
        bus_if.in_exc     = exc;
        bus_if.stage_exc  = stage_exc;
        bus_if.in_wr_en   = wr_en;
        bus_if.in_wr_addr = wr_addr;
        bus_if.in_tnew    = tnew;
        bus_if.in_payload = payload;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Checks every output against an expected bubble/instruction image.
    task automatic checkAll(input string tag, input logic valid, input logic [31:0] pc,
                            input logic bd, input logic [4:0] exc, input logic wr_en,
                            input logic [4:0] wr_addr, input logic [1:0] tnew,
                            input logic [95:0] payload);
        checkOutput({tag, ".valid"},   128'(bus_if.out_valid),   128'(valid));
        checkOutput({tag, ".pc"},      128'(bus_if.out_pc),      128'(pc));
        checkOutput({tag, ".bd"},      128'(bus_if.out_bd),      128'(bd));
        checkOutput({tag, ".exc"},     128'(bus_if.out_exc),     128'(exc));
        checkOutput({tag, ".wr_en"},   128'(bus_if.out_wr_en),   128'(wr_en));
        checkOutput({tag, ".wr_addr"}, 128'(bus_if.out_wr_addr), 128'(wr_addr));
        checkOutput({tag, ".tnew"},    128'(bus_if.out_tnew),    128'(tnew));
        checkOutput({tag, ".payload"}, 128'(bus_if.out_payload), 128'(payload));
    endtask

    localparam logic [95:0] P1 = {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    localparam logic [95:0] P2 = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0};
    localparam logic [95:0] P3 = {32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Power-on reset
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);
        #2;
        checkAll("reset", 1'b0, 32'h3000, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);
        @(negedge clk);
        reset = 1'b0;

        // Plain load: tnew 3 ages to 2, stage_exc taken when in_exc is 0
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3100, 1'b1, 5'd0, 5'd5, 1'b1, 5'd5, 2'd3, P1);
        @(negedge clk);
        checkAll("load1", 1'b1, 32'h3100, 1'b1, 5'd5, 1'b1, 5'd5, 2'd2, P1);

        // Asynchronous reset in mid-cycle clears immediately
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_rst", 1'b0, 32'h3000, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3004, 1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 2'd2, P2);
        @(negedge clk);
        checkAll("load_3004", 1'b1, 32'h3004, 1'b0, 5'd0, 1'b1, 5'd8, 2'd1, P2);

        // Hold for three cycles with changing inputs; tnew must not age
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h3008 + 32'(4 * i), 1'b1, 5'd10, 5'd12,
                          1'b1, 5'(20 + i), 2'd3, P3);
            @(negedge clk);
            checkAll("hold", 1'b1, 32'h3004, 1'b0, 5'd0, 1'b1, 5'd8, 2'd1, P2);
        end

        // Stall bubble: flush with en=0 keeps in_pc/in_bd
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3010, 1'b1, 5'd10, 5'd4, 1'b1, 5'd9, 2'd3, P3);
        @(negedge clk);
        checkAll("flush_stall", 1'b0, 32'h3010, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);

        // Second bubble in a row, then hold the bubble
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3014, 1'b0, 5'd4, 5'd0, 1'b1, 5'd3, 2'd2, P1);
        @(negedge clk);
        checkAll("flush_again", 1'b0, 32'h3014, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h3018, 1'b1, 5'd4, 5'd0, 1'b1, 5'd3, 2'd2, P1);
        @(negedge clk);
        checkAll("hold_bubble", 1'b0, 32'h3014, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);

        // $0 write guard, stage exception merge, tnew 0 saturates
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3020, 1'b0, 5'd0, 5'd12, 1'b1, 5'd0, 2'd0, P3);
        @(negedge clk);
        checkAll("guard_sat", 1'b1, 32'h3020, 1'b0, 5'd12, 1'b0, 5'd0, 2'd0, P3);

        // Older exception wins; tnew equal to decrement gives 0; $31 writes
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3024, 1'b1, 5'd4, 5'd12, 1'b1, 5'd31, 2'd1, P1);
        @(negedge clk);
        checkAll("merge_old", 1'b1, 32'h3024, 1'b1, 5'd4, 1'b1, 5'd31, 2'd0, P1);

        // req together with flush and en: redirect to handler
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h3028, 1'b1, 5'd5, 5'd10, 1'b1, 5'd7, 2'd3, P2);
        @(negedge clk);
        checkAll("req_flush", 1'b0, 32'h4180, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);

        // Reload after redirect
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3030, 1'b0, 5'd0, 5'd10, 1'b1, 5'd2, 2'd3, P2);
        @(negedge clk);
        checkAll("reload", 1'b1, 32'h3030, 1'b0, 5'd10, 1'b1, 5'd2, 2'd2, P2);

        // flush beats en=1
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h3034, 1'b0, 5'd0, 5'd12, 1'b1, 5'd6, 2'd2, P3);
        @(negedge clk);
        checkAll("flush_en", 1'b0, 32'h3034, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);

        // req alone with en=0, then hold keeps the handler bubble
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h3038, 1'b1, 5'd0, 5'd0, 1'b1, 5'd6, 2'd2, P3);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h303C, 1'b1, 5'd4, 5'd0, 1'b1, 5'd6, 2'd2, P3);
        @(negedge clk);
        checkAll("req_only", 1'b0, 32'h4180, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h3040, 1'b1, 5'd4, 5'd0, 1'b1, 5'd6, 2'd2, P3);
        @(negedge clk);
        checkAll("hold_req", 1'b0, 32'h4180, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0, 96'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
